// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  function automatic int slice_count(input int width, input int digit);
    return width / digit;
  endfunction

  // A one-slice configuration still needs a 1-bit counter.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/Busy/Done handshake plus operand and result buses.
interface serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] D;
  logic             Bout;

  modport master (
    output Start, A, B, Bin,
    input  Busy, Done, D, Bout
  );

  modport slave (
    input  Start, A, B, Bin,
    output Busy, Done, D, Bout
  );
endinterface

// File: rtl/serial_subtractor_digit.sv
// One DIGIT-bit ripple slice: {bout, diff} = a - b - bin.
module digit_subtractor #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout
);
  // The extra MSB of the widened difference goes to 1 exactly when the slice underflows.
  assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: {Bout,D} = A - B - Bin, one DIGIT slice per clock, LSB first.
import sub_pkg::*;

module serial_subtractor #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input logic                Clk,
  input logic                Reset_n,
  serial_subtractor_if.slave bus
);
  localparam int N  = slice_count(WIDTH, DIGIT);
  localparam int CW = cnt_bits(N);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  sub_state_t         state_q, state_d;
  logic               accept;
  logic               last;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               borrow_q;
  logic [WIDTH-DIGIT-1:0] res_q;
  logic [WIDTH-1:0]   res_next;
  logic [WIDTH-1:0]   d_q;
  logic               bout_q;
  logic [DIGIT-1:0]   slice;
  logic               slice_bout;

  digit_subtractor #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .bin  (borrow_q),
    .diff (slice),
    .bout (slice_bout)
  );

  assign last     = (cnt_q == CW'(N - 1));
  assign res_next = {slice, res_q};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        // A Start in the DONE cycle chains straight into the next operation.
        if (bus.Start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
    end else if (accept) begin
      a_q      <= bus.A;
      b_q      <= bus.B;
      borrow_q <= bus.Bin;
      cnt_q    <= '0;
      res_q    <= '0;
    end else if (state_q == RUN) begin
      a_q      <= a_q >> DIGIT;
      b_q      <= b_q >> DIGIT;
      borrow_q <= slice_bout;
      cnt_q    <= cnt_q + CW'(1);
      res_q    <= res_next[WIDTH-1:DIGIT];
      // Visible result only updates once the whole word is assembled.
      if (last) begin
        d_q    <= res_next;
        bout_q <= slice_bout;
      end
    end
  end

  assign bus.Busy = (state_q == RUN);
  assign bus.Done = (state_q == DONE);
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against a 17-bit reference subtract.
module tb_serial_subtractor;
  import sub_pkg::*;

  typedef struct packed {
    logic        bout;
    logic [15:0] d;
  } res_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  serial_subtractor_if #(.WIDTH(16)) bus ();

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  res_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] r;
    r = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    return r;
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic do_start(input logic [15:0] a, input logic [15:0] b, input logic bin);
    bus.Start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    exp_q.push_back(model(a, b, bin));
    @(posedge Clk);
    #1 bus.Start = 1'b0;
  endtask

  // Returns at the negedge where Done is seen (or after the budget expires).
  task automatic wait_done(input string tag, input bit disturb);
    int   k;
    int   busy_cnt = 0;
    bit   seen = 1'b0;
    res_t e;
    for (k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (disturb && k == 2) begin
        bus.Start = 1'b1;
        bus.A     = 16'($urandom);
        bus.B     = 16'($urandom);
        bus.Bin   = ~bus.Bin;
      end
      if (disturb && k == 3) bus.Start = 1'b0;
      if (bus.Done) begin
        seen = 1'b1;
        break;
      end
      if (bus.Busy) busy_cnt++;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, " latency"}, 32'(k - 1), 32'd4);
      chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd4);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, " result"}, 32'({bus.Bout, bus.D}), 32'(e));
  endtask

  initial begin
    logic [15:0] hold_d;
    logic        hold_b;
    bit          moved;
    bit          any_done;
    logic [15:0] ra, rb;

    bus.Start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;

    // Reset state
    repeat (3) @(negedge Clk);
    chk("reset D", 32'(bus.D), 32'd0);
    chk("reset Bout", 32'(bus.Bout), 32'd0);
    chk("reset Done", 32'(bus.Done), 32'd0);
    chk("reset Busy", 32'(bus.Busy), 32'd0);
    Reset_n = 1'b1;

    // Basic subtract with borrow-in
    @(negedge Clk);
    do_start(16'h1234, 16'h0234, 1'b1);
    wait_done("basic", 1'b0);

    // Result hold while idle
    hold_d   = bus.D;
    hold_b   = bus.Bout;
    moved    = 1'b0;
    any_done = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (bus.D !== hold_d || bus.Bout !== hold_b) moved = 1'b1;
      if (bus.Done) any_done = 1'b1;
    end
    chk("hold result_moved", 32'(moved), 32'd0);
    chk("hold done_pulse", 32'(any_done), 32'd0);

    // Reset in the second RUN cycle aborts the operation
    @(negedge Clk);
    do_start(16'h00FF, 16'h0001, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    chk("abort busy_before", 32'(bus.Busy), 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("abort D", 32'(bus.D), 32'd0);
    chk("abort Bout", 32'(bus.Bout), 32'd0);
    chk("abort Done", 32'(bus.Done), 32'd0);
    chk("abort Busy", 32'(bus.Busy), 32'd0);
    void'(exp_q.pop_front());
    @(negedge Clk);
    Reset_n  = 1'b1;
    any_done = 1'b0;
    repeat (8) begin
      @(negedge Clk);
      if (bus.Done) any_done = 1'b1;
    end
    chk("abort no_done", 32'(any_done), 32'd0);

    // Underflow / wrap-around
    @(negedge Clk);
    do_start(16'h0005, 16'h0007, 1'b0);
    wait_done("wrap 5-7", 1'b0);
    @(negedge Clk);
    do_start(16'h0000, 16'h0000, 1'b1);
    wait_done("wrap 0-0-1", 1'b0);
    @(negedge Clk);
    do_start(16'hFFFF, 16'hFFFF, 1'b1);
    wait_done("wrap F-F-1", 1'b0);

    // Start and operand changes during RUN are ignored
    @(negedge Clk);
    do_start(16'h8000, 16'h0001, 1'b1);
    wait_done("run_ignore", 1'b1);
    any_done = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      if (bus.Done) any_done = 1'b1;
    end
    chk("run_ignore single_done", 32'(any_done), 32'd0);

    // Back-to-back: second Start lands in the DONE cycle
    @(negedge Clk);
    do_start(16'hA5A5, 16'h5A5A, 1'b0);
    wait_done("b2b first", 1'b0);
    do_start(16'h0100, 16'h0200, 1'b1);
    wait_done("b2b second", 1'b0);

    // Random operands, Bin alternating
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_start(ra, rb, i[0]);
      wait_done("rand", 1'b0);
    end

    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle 16-bit subtractor with borrow-in and borrow-out; it is the subtract-direction counterpart of the team's LPM adder datapath.
- Computes {Bout,D} = A - B - Bin, one DIGIT-bit slice per clock, LSB slice first.
- Uses a Start/Busy/Done handshake, so it sits in the ALU datapath where an area-cheap subtract is preferred over a full-width combinational one.

Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 4, bits processed per cycle. WIDTH must be an integer multiple of DIGIT; elaboration fails otherwise.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled on a rising edge only in IDLE or DONE.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- Bin  input  1  borrow-in; captured on the accepting edge.
- Busy  output  1  high while a subtraction is in progress (state RUN).
- Done  output  1  one-cycle pulse: D and Bout are valid.
- D  output  WIDTH  difference; held stable from Done until the next Done.
- Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned); held like D.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - state=IDLE; D=0, Bout=0, Done=0, Busy=0; internal shift registers, borrow and slice counter all 0.
  - Reset deasserts synchronously to Clk; the first legal Start is on the first edge with Reset_n=1.
- States are IDLE, RUN and DONE.
  - IDLE: Busy=0, Done=0. On an edge with Start=1: capture A, B, Bin; slice counter=0; go to RUN.
  - RUN: Busy=1.
    - Each edge computes {borrow', slice} = a[DIGIT-1:0] - b[DIGIT-1:0] - borrow.
    - The slice is shifted into the MSB end of the result register; the a and b shift registers shift right by DIGIT; the counter increments.
    - On the edge that processes slice N-1 (N = WIDTH/DIGIT): D <= full result, Bout <= final borrow, go to DONE.
  - DONE: Done=1, Busy=0, for exactly one cycle.
    - Start=1 on this edge is accepted as in IDLE (back-to-back, no bubble) and goes to RUN.
    - Otherwise go to IDLE.
- Latency:
  - Start sampled at edge t; Done high in the cycle after edge t+N, i.e. N=4 cycles at defaults.
  - Throughput is one result per N+1 cycles.
- Start while in RUN is ignored. A, B and Bin changes while in RUN do not affect the result in flight.
- D and Bout change only on the edge entering DONE. Between operations they hold the previous result and never show partial slices.
- Arithmetic:
  - Modulo 2^WIDTH, unsigned. Borrow chains across slices exactly as a WIDTH-bit ripple subtract would.
  - Wrap-around example: 0 - 1 gives D=all ones, Bout=1.
- Reset mid-RUN aborts the operation. D and Bout return to 0 and no Done is produced.

Decomposition:
- Package sub_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t.
  - Default WIDTH and DIGIT constants.
  - A localparam function for the slice count N and the counter width $clog2(N).
- One combinational sub-module, digit_subtractor (DIGIT-bit a, b, borrow in -> DIGIT-bit diff, borrow out), instantiated once.
- FSM, shift registers and counter are in serial_subtractor.

Test Plan:
1. Reset mid-RUN:
   - Hold Reset_n=0 -> D=0, Bout=0, Done=0, Busy=0.
   - Start A=16'h00FF, B=16'h0001, then pull Reset_n low in the 2nd RUN cycle -> outputs 0 immediately and no Done pulse.
2. Basic subtract and latency:
   - A=16'h1234, B=16'h0234, Bin=1 -> D=16'h0FFF, Bout=0.
   - Done pulses exactly 4 cycles after the Start edge; Busy is high for those 4 cycles.
3. Underflow / wrap-around:
   - A=16'h0005, B=16'h0007, Bin=0 -> D=16'hFFFE, Bout=1.
   - A=16'h0000, B=16'h0000, Bin=1 -> D=16'hFFFF, Bout=1.
   - A=16'hFFFF, B=16'hFFFF, Bin=1 -> D=16'hFFFF, Bout=1.
4. Handshake rules:
   - Start re-asserted, and A/B/Bin changed, during RUN -> result still matches the originally captured operands; only one Done.
   - Start asserted in the DONE cycle -> second Done arrives 4 cycles later with no IDLE cycle between.
5. Result hold:
   - After Done, drop Start for 10 cycles -> D and Bout are unchanged and Done stays 0.
6. Randomized check:
   - 200 $urandom operand sets with Bin alternating 0/1.
   - Each Done is checked against {Bout,D} == {1'b0,A} - {1'b0,B} - Bin, using a 17-bit golden model.
